// File: rtl/serdes_pkg.sv
// Types and helpers shared by the serial transmit (PISO) and capture (SIPO) paths.
package serdes_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Bit-index counter width; a 1-bit word still needs a 1-bit counter.
    function automatic int ser_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a word over valid/ready and shifts it out
// one bit per shift_en tick, framed by sout_valid/sout_last, with back-to-back reload.
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int             CW       = ser_cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             sout_last_q, sout_last_d;
    logic             accept;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        sout_last_d  = sout_last_q;

        // Ready is withheld while reset is applied so nothing looks accepted then.
        in_ready = rst && shift_en && ((state_q == IDLE) || (cnt_q == LAST_IDX));
        accept   = in_valid && in_ready;

        if (accept) begin
            sout_d       = head_bit(in_data);
            shreg_d      = advance(in_data);
            cnt_d        = '0;
            sout_valid_d = 1'b1;
            sout_last_d  = (WIDTH == 1);
            state_d      = SHIFT;
        end else if (shift_en && (state_q == SHIFT)) begin
            if (cnt_q != LAST_IDX) begin
                sout_d      = head_bit(shreg_q);
                shreg_d     = advance(shreg_q);
                cnt_d       = cnt_q + 1'b1;
                sout_last_d = ((cnt_q + 1'b1) == LAST_IDX);
            end else begin
                state_d      = IDLE;
                sout_valid_d = 1'b0;
                sout_last_d  = 1'b0;
                sout_d       = IDLE_LEVEL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            sout_q       <= IDLE_LEVEL;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sout_last_q  <= sout_last_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_last_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed framing scenarios plus randomized traffic against
// a word/bit-position reference model on three parameterisations.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       shift_en = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] d_m = '0;
    logic [7:0] d_l = '0;
    logic [0:0] d_w = '0;

    logic rdy_m, so_m, sv_m, sl_m, bz_m;
    logic rdy_l, so_l, sv_l, sl_l, bz_l;
    logic rdy_w, so_w, sv_w, sl_w, bz_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .shift_en(shift_en), .in_data(d_m), .in_valid(in_valid),
        .in_ready(rdy_m), .sout(so_m), .sout_valid(sv_m), .sout_last(sl_m), .busy(bz_m));

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .shift_en(shift_en), .in_data(d_l), .in_valid(in_valid),
        .in_ready(rdy_l), .sout(so_l), .sout_valid(sv_l), .sout_last(sl_l), .busy(bz_l));

    piso_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .shift_en(shift_en), .in_data(d_w), .in_valid(in_valid),
        .in_ready(rdy_w), .sout(so_w), .sout_valid(sv_w), .sout_last(sl_w), .busy(bz_w));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a word in flight and how many of its bits have already been shown.
    typedef struct {
        bit         act;
        int         pos;
        logic [7:0] word;
    } mdl_t;

    mdl_t mm, ml, mw;

    function automatic bit m_rdy(input mdl_t m, input int w);
        return rst && shift_en && (!m.act || (m.pos == w - 1));
    endfunction

    function automatic logic m_bit(input mdl_t m, input int w, input bit msb, input logic idle);
        if (!m.act) return idle;
        return m.word[msb ? (w - 1 - m.pos) : m.pos];
    endfunction

    function automatic mdl_t m_next(input mdl_t m, input int w, input bit se, input bit acc,
                                    input logic [7:0] d);
        mdl_t r = m;
        if (!se) return r;
        if (acc) begin
            r.act = 1'b1; r.pos = 0; r.word = d;
        end else if (m.act && (m.pos < w - 1)) begin
            r.pos = m.pos + 1;
        end else begin
            r.act = 1'b0; r.pos = 0;
        end
        return r;
    endfunction

    function automatic mdl_t m_reset();
        mdl_t r;
        r.act = 1'b0; r.pos = 0; r.word = '0;
        return r;
    endfunction

    task automatic check_outs(input string p, input mdl_t m, input int w, input bit msb,
                              input logic idle, input logic so, input logic sv,
                              input logic sl, input logic bz);
        check({p, ".sout"},  so, m_bit(m, w, msb, idle));
        check({p, ".valid"}, sv, m.act);
        check({p, ".last"},  sl, m.act && (m.pos == w - 1));
        check({p, ".busy"},  bz, m.act);
    endtask

    logic [7:0]  w_a5 = 8'hA5;
    logic [7:0]  w_f0 = 8'hF0;
    logic [15:0] w_b2b = 16'hA53C;
    bit er_m, er_l, er_w, acc_m, acc_l, acc_w;
    bit hold_m, hold_l, hold_w;

    initial begin
        // Reset with a pending word: nothing may be offered or shown.
        shift_en = 1'b1; in_valid = 1'b1; d_m = 8'hA5; d_l = 8'h01; d_w = 1'b1;
        step(); step();
        check("rst.ready", rdy_m, 1'b0);
        check("rst.sout",  so_m, 1'b0);
        check("rst.valid", sv_m, 1'b0);
        check("rst.busy",  bz_m, 1'b0);
        check("rst.idle_lsb", so_l, 1'b1);
        rst = 1'b1;
        #1;
        check("a5.ready0", rdy_m, 1'b1);
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check("a5.sout",  so_m, w_a5[8 - i]);
            check("a5.valid", sv_m, 1'b1);
            check("a5.last",  sl_m, i == 8);
            check("a5.ready", rdy_m, i == 8);
            check("lsb01.sout", so_l, i == 1);
            if (i == 1) begin
                check("w1.valid", sv_w, 1'b1);
                check("w1.last",  sl_w, 1'b1);
                check("w1.sout",  so_w, 1'b1);
            end
            if (i == 2) check("w1.idle", sv_w, 1'b0);
            step();
        end
        check("a5.idle_valid", sv_m, 1'b0);
        check("a5.idle_busy",  bz_m, 1'b0);
        check("a5.idle_sout",  so_m, 1'b0);
        check("lsb.idle_sout", so_l, 1'b1);

        // Back-to-back words with in_valid held.
        in_valid = 1'b1; d_m = 8'hA5;
        step();
        d_m = 8'h3C;
        for (int i = 1; i <= 16; i++) begin
            if (i == 9) in_valid = 1'b0;
            check("b2b.sout",  so_m, w_b2b[16 - i]);
            check("b2b.valid", sv_m, 1'b1);
            check("b2b.last",  sl_m, (i == 8) || (i == 16));
            step();
        end
        check("b2b.idle", sv_m, 1'b0);

        // Slow tick: stray in_valid between ticks is ignored.
        shift_en = 1'b0; in_valid = 1'b1; d_m = 8'h55;
        #1;
        check("tick.stray_ready", rdy_m, 1'b0);
        step();
        in_valid = 1'b0;
        check("tick.stray_valid", sv_m, 1'b0);
        for (int k = 0; k < 36; k++) begin
            shift_en = (k % 4 == 0);
            in_valid = (k == 0) || (k == 30);
            d_m = (k == 0) ? 8'hF0 : 8'hFF;
            #1;
            if (k == 30) check("tick.ready30", rdy_m, 1'b0);
            step();
            if (k < 32) begin
                check("tick.sout",  so_m, w_f0[7 - k / 4]);
                check("tick.valid", sv_m, 1'b1);
                check("tick.last",  sl_m, (k / 4) == 7);
            end else begin
                check("tick.idle", sv_m, 1'b0);
            end
        end

        // Asynchronous reset mid-word.
        shift_en = 1'b1; in_valid = 1'b1; d_m = 8'h10; d_l = 8'h00;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("arst.pre_sout_m", so_m, 1'b1);
        check("arst.pre_sout_l", so_l, 1'b0);
        check("arst.pre_busy",   bz_m, 1'b1);
        #3;
        rst = 1'b0;
        #1;
        check("arst.valid",  sv_m, 1'b0);
        check("arst.last",   sl_m, 1'b0);
        check("arst.busy",   bz_m, 1'b0);
        check("arst.sout_m", so_m, 1'b0);
        check("arst.sout_l", so_l, 1'b1);
        step(); step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("arst.no_resume", sv_m, 1'b0);
        end

        // Randomized traffic against the model.
        rst = 1'b0; in_valid = 1'b0;
        step();
        rst = 1'b1;
        mm = m_reset(); ml = m_reset(); mw = m_reset();
        hold_m = 1'b0; hold_l = 1'b0; hold_w = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            check_outs("rm", mm, 8, 1'b1, 1'b0, so_m, sv_m, sl_m, bz_m);
            check_outs("rl", ml, 8, 1'b0, 1'b1, so_l, sv_l, sl_l, bz_l);
            check_outs("rw", mw, 1, 1'b1, 1'b0, so_w, sv_w, sl_w, bz_w);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                #1;
                mm = m_reset(); ml = m_reset(); mw = m_reset();
                hold_m = 1'b0; hold_l = 1'b0; hold_w = 1'b0;
                check_outs("rrm", mm, 8, 1'b1, 1'b0, so_m, sv_m, sl_m, bz_m);
                check("rr.ready", rdy_m, 1'b0);
                step();
                rst = 1'b1;
            end else begin
                shift_en = ($urandom_range(0, 3) != 0);
                in_valid = ($urandom_range(0, 9) < 6);
                if (!hold_m) d_m = 8'($urandom);
                if (!hold_l) d_l = 8'($urandom);
                if (!hold_w) d_w = 1'($urandom);
                #1;
                er_m = m_rdy(mm, 8); er_l = m_rdy(ml, 8); er_w = m_rdy(mw, 1);
                check("rm.ready", rdy_m, er_m);
                check("rl.ready", rdy_l, er_l);
                check("rw.ready", rdy_w, er_w);
                acc_m = in_valid && er_m; acc_l = in_valid && er_l; acc_w = in_valid && er_w;
                @(posedge clk);
                mm = m_next(mm, 8, shift_en, acc_m, d_m);
                ml = m_next(ml, 8, shift_en, acc_l, d_l);
                mw = m_next(mw, 1, shift_en, acc_w, {7'b0, d_w});
                hold_m = in_valid && !acc_m;
                hold_l = in_valid && !acc_l;
                hold_w = in_valid && !acc_w;
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
